// File: rtl/stack_rpn_seq_if.sv
// Token stream in and result stream out for the RPN stack sequencer.
interface stack_rpn_seq_if #(
  parameter int unsigned W = 8
) ();
  logic         tok_valid;
  logic         tok_ready;
  logic [1:0]   tok_kind;
  logic [W-1:0] tok_data;
  logic [1:0]   tok_opsel;
  logic         res_valid;
  logic [W-1:0] res_data;
  logic         res_err;

  modport master (
    output tok_valid, tok_kind, tok_data, tok_opsel,
    input  tok_ready, res_valid, res_data, res_err
  );

  modport slave (
    input  tok_valid, tok_kind, tok_data, tok_opsel,
    output tok_ready, res_valid, res_data, res_err
  );
endinterface

// File: rtl/stack_rpn_seq.sv
// RPN expression sequencer: evaluates tokens on an external stack through PUSH/POP only,
// reports one result or error per expression and drains the stack after an error.
module stack_rpn_seq #(
  parameter int unsigned W       = 8,
  parameter logic [3:0]  OP_PUSH = 4'd0,
  parameter logic [3:0]  OP_POP  = 4'd1
) (
  input  logic           clk,
  input  logic           rst,
  stack_rpn_seq_if.slave bus,
  output logic [3:0]     st_op,
  output logic [W-1:0]   st_in,
  output logic           st_apply,
  input  logic [W-1:0]   st_head,
  input  logic           st_empty,
  input  logic           st_valid
);

  typedef enum logic [3:0] {
    StIdle, StPushN, StChkN, StPopB, StChkB, StPopA, StChkA, StPushR,
    StChkR, StPopE, StChkE, StRes, StErr, StDrain, StPopD, StDrainW
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
  logic [1:0]   opsel_q, opsel_d;
  logic [W-1:0] alu;

  logic         tok_ready_q, tok_ready_d;
  logic [3:0]   st_op_q, st_op_d;
  logic [W-1:0] st_in_q, st_in_d;
  logic         st_apply_q, st_apply_d;
  logic         res_valid_q, res_valid_d;
  logic [W-1:0] res_data_q, res_data_d;
  logic         res_err_q, res_err_d;

  // A is the deeper operand; all results wrap mod 2^W.
  always_comb begin
    unique case (opsel_q)
      2'd0:    alu = a_q + b_q;
      2'd1:    alu = a_q - b_q;
      2'd2:    alu = a_q * b_q;
      default: alu = a_q & b_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    opsel_d = opsel_q;
    unique case (state_q)
      StIdle: begin
        // tok_ready_q gates the transfer so the first cycle out of reset takes nothing.
        if (bus.tok_valid && tok_ready_q) begin
          unique case (bus.tok_kind)
            2'd0: state_d = StPushN;
            2'd1: begin
              if (st_empty) begin
                state_d = StErr;
              end else begin
                b_d     = st_head;
                opsel_d = bus.tok_opsel;
                state_d = StPopB;
              end
            end
            2'd2: begin
              if (st_empty) begin
                state_d = StErr;
              end else begin
                r_d     = st_head;
                state_d = StPopE;
              end
            end
            default: state_d = StErr;
          endcase
        end
      end
      StPushN: state_d = StChkN;
      StChkN:  state_d = st_valid ? StIdle : StErr;
      StPopB:  state_d = StChkB;
      StChkB: begin
        if (!st_valid || st_empty) begin
          state_d = StErr;
        end else begin
          a_d     = st_head;
          state_d = StPopA;
        end
      end
      StPopA:  state_d = StChkA;
      StChkA: begin
        if (!st_valid) begin
          state_d = StErr;
        end else begin
          r_d     = alu;
          state_d = StPushR;
        end
      end
      StPushR: state_d = StChkR;
      StChkR:  state_d = st_valid ? StIdle : StErr;
      StPopE:  state_d = StChkE;
      StChkE:  state_d = (!st_valid || !st_empty) ? StErr : StRes;
      StRes:   state_d = StIdle;
      StErr:   state_d = StDrain;
      StDrain: state_d = st_empty ? StIdle : StPopD;
      StPopD:  state_d = StDrainW;
      StDrainW: state_d = StDrain;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    tok_ready_d = (state_d == StIdle);
    st_apply_d  = 1'b0;
    st_op_d     = st_op_q;
    st_in_d     = st_in_q;
    unique case (state_d)
      StPushN: begin
        st_apply_d = 1'b1;
        st_op_d    = OP_PUSH;
        st_in_d    = bus.tok_data;
      end
      StPushR: begin
        st_apply_d = 1'b1;
        st_op_d    = OP_PUSH;
        st_in_d    = r_d;
      end
      StPopB, StPopA, StPopE, StPopD: begin
        st_apply_d = 1'b1;
        st_op_d    = OP_POP;
      end
      default: ;
    endcase
    res_valid_d = (state_d == StRes) || (state_d == StErr);
    res_err_d   = (state_d == StErr);
    res_data_d  = (state_d == StRes) ? r_q : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      opsel_q     <= '0;
      tok_ready_q <= 1'b0;
      st_op_q     <= '0;
      st_in_q     <= '0;
      st_apply_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      r_q         <= r_d;
      opsel_q     <= opsel_d;
      tok_ready_q <= tok_ready_d;
      st_op_q     <= st_op_d;
      st_in_q     <= st_in_d;
      st_apply_q  <= st_apply_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
  end

  assign bus.tok_ready = tok_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_err   = res_err_q;
  assign st_op         = st_op_q;
  assign st_in         = st_in_q;
  assign st_apply      = st_apply_q;

endmodule

// File: doc/stack_rpn_seq.md
Name: stack_rpn_seq

Overview:
Hardware initiator for the stack block `main`. It accepts a stream of reverse-Polish tokens over a valid/ready handshake. It drives the stack's op/in/apply port to evaluate them, using the stack only through PUSH and POP plus the head/empty/valid outputs. It reports one result or error per expression and drains the stack after an error.

Parameters:
W, 8, data width; must match the stack's W.
OP_PUSH, 4'd0, stack opcode for push.
OP_POP, 4'd1, stack opcode for pop.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset (rst=0 resets on the clk edge)
tok_valid  in  1  token offered
tok_ready  out  1  sequencer can accept a token
tok_kind  in  2  token kind: 0 number, 1 operator, 2 end-of-expression, 3 illegal
tok_data  in  W  number value (used only for kind 0)
tok_opsel  in  2  operator: 0 add, 1 sub (A-B), 2 mul (low W bits), 3 bitwise and
st_op  out  4  to stack op
st_in  out  W  to stack in
st_apply  out  1  to stack apply; one-cycle pulse per command
st_head  in  W  from stack head
st_empty  in  1  from stack empty
st_valid  in  1  from stack valid
res_valid  out  1  one-cycle result strobe
res_data  out  W  result value (0 when res_err=1)
res_err  out  1  qualifies res_valid as an error

Behaviour:
- Registers and outputs:
  - All outputs are registered.
  - While rst=0, every output is 0, the FSM is forced to IDLE, and A, B and R are cleared.
  - tok_ready rises on the first cycle after rst returns to 1.
- Stack timing contract:
  - The stack samples st_op/st_in while st_apply=1 at a clk edge.
  - st_head, st_empty and st_valid reflect that command in the next cycle; the sequencer samples them in CHK_* states.
  - Outside ISSUE/POP/PUSH states, st_apply=0 and st_op/st_in hold their last values.
- Handshake:
  - A token transfers on an edge where tok_valid=1 and tok_ready=1.
  - tok_ready=1 only in IDLE.
  - tok_valid while not ready is ignored; the token is neither consumed nor stored.
- States and transitions:
  - IDLE, number token: latch tok_data -> PUSH_N (apply OP_PUSH, st_in=data) -> CHK_N -> IDLE. tok_ready is low for exactly 2 cycles.
  - IDLE, operator token, st_empty=1: -> ERR.
  - IDLE, operator token, otherwise: B<=st_head.
    - POP_B -> CHK_B: if st_empty=1, -> ERR (single operand); else A<=st_head.
    - POP_A -> CHK_A -> PUSH_R (st_in=R) -> CHK_R -> IDLE.
    - tok_ready is low for 6 cycles.
  - IDLE, end token, st_empty=1: -> ERR (empty expression).
  - IDLE, end token, otherwise: R<=st_head -> POP_E -> CHK_E.
    - CHK_E, st_empty=0: -> ERR (leftover operands).
    - CHK_E, st_empty=1: -> RES.
  - IDLE, kind 3: -> ERR.
  - Any CHK_* state with st_valid=0: -> ERR, overriding the other checks.
  - RES: res_valid=1, res_err=0, res_data=R for one cycle -> IDLE.
  - ERR: res_valid=1, res_err=1, res_data=0 for one cycle -> DRAIN.
  - DRAIN: st_empty=1 -> IDLE; else -> POP_D (apply OP_POP) -> DRAIN_W -> DRAIN. Drain ignores st_valid.
- Arithmetic:
  - R = A op B, truncated mod 2^W.
  - sub uses two's-complement wrap.
  - mul keeps the low W bits of the 2W product.
  - A is the older (deeper) operand, B the top.
- Reset mid-operation:
  - Aborts without issuing further applies.
  - The stack shares rst and clears itself; no result strobe is produced for the aborted expression.
- Stack overflow: reported by the stack through st_valid=0 at CHK_N or CHK_R and handled as ERR.

Test Plan:
1. Reset: hold rst=0 2 cycles with tok_valid=1 -> all outputs 0, no st_apply; tok_ready=1 the cycle after release.
2. Tokens num 10, end -> st_apply pulses with st_op=0/st_in=10, then st_op=1; res_valid=1, res_data=10, res_err=0; stack empty afterwards.
3. Arithmetic, W=8:
   - "3 4 add end" -> res_data=7.
   - "5 3 sub end" -> 2.
   - "3 5 sub end" -> 254.
   - "20 13 mul end" -> 4 (260 mod 256).
   - "12 10 and end" -> 8.
   - tok_ready low exactly 6 cycles per operator.
4. Underflow: "7 add" -> pop of 7 seen, then res_err=1, res_data=0; DRAIN issues no further pops (already empty); next "9 end" -> 9.
5. Leftover and illegal:
   - "1 2 end" -> res_err=1, then exactly one drain pop; stack empty; tok_ready returns.
   - Token kind 3 -> res_err=1 with no stack command issued.
6. Mid-operation reset and backpressure:
   - rst=0 during CHK_A of "3 4 add" -> no res_valid; IDLE after release.
   - tok_valid pulsed while tok_ready=0 -> token not consumed, no extra st_apply.
